scan_key_sequencer: RTL and testbench

Transmit side of the scan-unlock protocol. Holds a software-loaded table of `scan_key_number` key words and, on `start`, drives them onto the `scan_key` bus one word per clock, in table order. It then waits a bounded number of cycles for the scan-control block to assert `scan_unlock` and reports `done` or `fail`. It sits between the test/debug controller (register writes) and the scan-control unlock checker.

---
 rtl/scan_key_sequencer_if.sv | 31 +++
 rtl/scan_key_sequencer.sv | 117 +++++++++++
 tb/tb_scan_key_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/scan_key_sequencer_if.sv
// Bus bundle between the test/debug controller, the scan key sequencer and the
// scan-control unlock checker.
interface scan_key_sequencer_if #(
  parameter int scan_key_width  = 32,
  parameter int scan_key_number = 8
);
  localparam int aw = $clog2(scan_key_number);

  logic                      key_wr_en;
  logic [aw-1:0]             key_wr_addr;
  logic [scan_key_width-1:0] key_wr_data;
  logic                      key_lock;
  logic                      start;
  logic                      clear;
  logic                      scan_unlock;
  logic [scan_key_width-1:0] scan_key;
  logic                      busy;
  logic                      done;
  logic                      fail;
  logic [aw:0]               words_sent;

  modport master (
    output key_wr_en, key_wr_addr, key_wr_data, key_lock, start, clear, scan_unlock,
    input  scan_key, busy, done, fail, words_sent
  );

  modport slave (
    input  key_wr_en, key_wr_addr, key_wr_data, key_lock, start, clear, scan_unlock,
    output scan_key, busy, done, fail, words_sent
  );
endinterface

// File: rtl/scan_key_sequencer.sv
// Transmit side of scan unlock: replays a write-protectable key table onto
// scan_key, then waits a bounded time for scan_unlock.
//   state | meaning
//   IDLE  | table writable, waiting for start
//   SEND  | one key word per cycle on scan_key
//   WAIT  | idle_word driven, timeout running
//   DONE  | unlocked, sticky until clear
//   FAIL  | timed out, table writable, sticky until clear
module scan_key_sequencer #(
  parameter int                        scan_key_width  = 32,
  parameter int                        scan_key_number = 8,
  parameter int                        unlock_timeout  = 16,
  parameter logic [scan_key_width-1:0] idle_word       = '0
) (
  input logic                 clk,
  input logic                 rst_n,
  scan_key_sequencer_if.slave bus
);
  localparam int          aw         = $clog2(scan_key_number);
  localparam int          cw         = (unlock_timeout > 1) ? $clog2(unlock_timeout) : 1;
  localparam int          tmo_m1     = unlock_timeout - 1;
  localparam logic [aw:0] words_full = scan_key_number[aw:0];
  localparam logic [aw:0] ws_one     = 1;
  localparam logic [cw-1:0] tmo_last = tmo_m1[cw-1:0];
  localparam logic [cw-1:0] tmo_one  = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_DONE,
    ST_FAIL
  } state_e;

  state_e                    state_q, state_d;
  logic [scan_key_width-1:0] scan_key_q, scan_key_d;
  logic [aw:0]               words_sent_q, words_sent_d;
  logic [cw-1:0]             tmo_q, tmo_d;
  logic                      lock_q, lock_d;
  logic [scan_key_width-1:0] key_tab_q [scan_key_number];
  logic [scan_key_width-1:0] key_tab_d [scan_key_number];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      scan_key_q   <= idle_word;
      words_sent_q <= '0;
      tmo_q        <= '0;
      lock_q       <= 1'b0;
      key_tab_q    <= '{default: '0};
    end else begin
      state_q      <= state_d;
      scan_key_q   <= scan_key_d;
      words_sent_q <= words_sent_d;
      tmo_q        <= tmo_d;
      lock_q       <= lock_d;
      key_tab_q    <= key_tab_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    scan_key_d   = idle_word;
    words_sent_d = words_sent_q;
    tmo_d        = tmo_q;
    lock_d       = lock_q | bus.key_lock;
    key_tab_d    = key_tab_q;

    // A write coinciding with the lock request is already protected.
    if (bus.key_wr_en && !lock_q && !bus.key_lock &&
        (state_q == ST_IDLE || state_q == ST_FAIL))
      key_tab_d[bus.key_wr_addr] = bus.key_wr_data;

    unique case (state_q)
      ST_IDLE: begin
        if (!bus.clear && bus.start) begin
          words_sent_d = '0;
          if (bus.scan_unlock) begin
            state_d = ST_DONE;
          end else begin
            state_d      = ST_SEND;
            scan_key_d   = key_tab_q[0];
            words_sent_d = ws_one;
          end
        end
      end
      ST_SEND: begin
        if (bus.clear) begin
          state_d = ST_IDLE;
        end else if (words_sent_q == words_full) begin
          state_d = ST_WAIT;
          tmo_d   = tmo_last;
        end else begin
          scan_key_d   = key_tab_q[words_sent_q[aw-1:0]];
          words_sent_d = words_sent_q + ws_one;
        end
      end
      ST_WAIT: begin
        // Unlock is tested before the terminal count so a late unlock still wins.
        if (bus.clear)             state_d = ST_IDLE;
        else if (bus.scan_unlock)  state_d = ST_DONE;
        else if (tmo_q == '0)      state_d = ST_FAIL;
        else                       tmo_d   = tmo_q - tmo_one;
      end
      ST_DONE, ST_FAIL: begin
        if (bus.clear) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.scan_key   = scan_key_q;
  assign bus.busy       = (state_q == ST_SEND) || (state_q == ST_WAIT);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.fail       = (state_q == ST_FAIL);
  assign bus.words_sent = words_sent_q;
endmodule

// File: tb/tb_scan_key_sequencer.sv
// Directed bench for scan_key_sequencer with a cycle-count reference model and
// a behavioural unlock checker driving scan_unlock.
module tb_scan_key_sequencer;
  localparam int N = 8;
  localparam int T = 16;
  localparam logic [31:0] IDLE_W = 32'h0;
  localparam int P_IDLE = 0, P_ACT = 1, P_DONE = 2, P_FAIL = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic force_unlock = 1'b0;
  logic chk_rst = 1'b0;
  logic chk_mask = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] key_ref [N] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004,
                               32'h5555_0005, 32'h6666_0006, 32'h7777_0007, 32'h8888_0008};

  scan_key_sequencer_if #(.scan_key_width(32), .scan_key_number(N)) bus ();

  scan_key_sequencer #(
    .scan_key_width (32),
    .scan_key_number(N),
    .unlock_timeout (T),
    .idle_word      (IDLE_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Unlock checker: advances on each matching word, unlock registered one cycle later.
  int   c_idx;
  logic c_unl;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || chk_rst) begin
      c_idx <= 0;
      c_unl <= 1'b0;
    end else begin
      c_unl <= (c_idx == N);
      if (c_idx < N && bus.scan_key == key_ref[c_idx]) c_idx <= c_idx + 1;
    end
  end
  assign bus.scan_unlock = force_unlock | (c_unl & ~chk_mask);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase plus cycles elapsed since start.
  int          m_ph = P_IDLE;
  int          m_t  = 0;
  int          m_ws = 0;
  bit          m_lock = 0;
  logic [31:0] m_tab [N] = '{default: '0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = P_IDLE; m_t = 0; m_ws = 0; m_lock = 0;
      foreach (m_tab[i]) m_tab[i] = '0;
    end else begin
      if (bus.key_wr_en && !m_lock && !bus.key_lock && (m_ph == P_IDLE || m_ph == P_FAIL))
        m_tab[bus.key_wr_addr] = bus.key_wr_data;
      if (bus.key_lock) m_lock = 1;
      case (m_ph)
        P_IDLE: if (!bus.clear && bus.start) begin
          m_ws = 0;
          if (bus.scan_unlock) m_ph = P_DONE;
          else begin m_ph = P_ACT; m_t = 1; m_ws = 1; end
        end
        P_ACT: begin
          if (bus.clear)                        m_ph = P_IDLE;
          else if (m_t > N && bus.scan_unlock)  m_ph = P_DONE;
          else if (m_t == N + T)                m_ph = P_FAIL;
          else begin
            m_t++;
            if (m_t <= N) m_ws = m_t;
          end
        end
        default: if (bus.clear) m_ph = P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_key;
    exp_key = (m_ph == P_ACT && m_t <= N) ? m_tab[m_t-1] : IDLE_W;
    chk("m_scan_key", bus.scan_key, exp_key);
    chk("m_busy", bus.busy, m_ph == P_ACT);
    chk("m_done", bus.done, m_ph == P_DONE);
    chk("m_fail", bus.fail, m_ph == P_FAIL);
    chk("m_words_sent", bus.words_sent, m_ws);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [31:0] data);
    bus.key_wr_en = 1'b1;
    bus.key_wr_addr = addr[2:0];
    bus.key_wr_data = data;
    tick();
    bus.key_wr_en = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
  endtask

  task automatic chk_reset();
    chk_rst = 1'b1; tick(); chk_rst = 1'b0;
  endtask

  task automatic go();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.key_wr_en = 0; bus.key_wr_addr = '0; bus.key_wr_data = '0;
    bus.key_lock = 0; bus.start = 0; bus.clear = 0;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_scan_key", bus.scan_key, 32'h0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_fail", bus.fail, 0);
    chk("rst_words", bus.words_sent, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < N; i++) wr(i, key_ref[i]);

    // nominal unlock
    chk_reset(); go();
    for (int c = 1; c <= 11; c++) begin
      if (c <= 8)  chk("nom_key", bus.scan_key, key_ref[c-1]);
      if (c == 9)  chk("nom_unl9", bus.scan_unlock, 0);
      if (c == 10) begin chk("nom_unl10", bus.scan_unlock, 1); chk("nom_done10", bus.done, 0); end
      if (c == 11) begin
        chk("nom_done", bus.done, 1); chk("nom_busy", bus.busy, 0); chk("nom_words", bus.words_sent, 8);
      end
      if (c < 11) tick();
    end
    do_clear();

    // wrong key: times out, start in FAIL ignored
    wr(3, 32'hDEAD_BEEF);
    chk_reset(); go();
    for (int c = 1; c <= 25; c++) begin
      if (c == 24) chk("wk_fail24", bus.fail, 0);
      if (c == 25) begin chk("wk_fail25", bus.fail, 1); chk("wk_done", bus.done, 0); end
      if (c < 25) tick();
    end
    go();
    chk("wk_start_in_fail", bus.fail, 1);
    chk("wk_start_busy", bus.busy, 0);
    wr(3, key_ref[3]);
    do_clear();
    chk("wk_cleared", bus.fail, 0);

    // abort in cycle 4
    chk_reset(); go();
    repeat (3) tick();
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
    chk("ab_busy", bus.busy, 0);
    chk("ab_words", bus.words_sent, 4);
    chk("ab_key", bus.scan_key, 32'h0);

    // already unlocked
    force_unlock = 1'b1; go();
    chk("au_done", bus.done, 1);
    chk("au_words", bus.words_sent, 0);
    chk("au_key", bus.scan_key, 32'h0);
    force_unlock = 1'b0;
    do_clear();

    // write protection: write during SEND, lock+write, write after lock
    chk_reset(); go(); tick();
    wr(5, 32'h5555_AAAA);
    repeat (8) tick();
    chk("wp_send_done", bus.done, 1);
    do_clear();
    bus.key_lock = 1'b1; wr(1, 32'hBAD0_0001); bus.key_lock = 1'b0;
    wr(2, 32'hBAD0_0002);
    chk_reset(); go();
    for (int c = 1; c <= 11; c++) begin
      if (c <= 8)  chk("wp_readback", bus.scan_key, key_ref[c-1]);
      if (c == 11) chk("wp_done", bus.done, 1);
      if (c < 11) tick();
    end
    do_clear();

    // unlock in last WAIT cycle wins over timeout
    chk_mask = 1'b1;
    chk_reset(); go();
    repeat (23) tick();
    force_unlock = 1'b1; tick(); force_unlock = 1'b0;
    chk("race_done", bus.done, 1);
    chk("race_fail", bus.fail, 0);
    do_clear();

    // reset mid-sequence clears table and lock
    go();
    repeat (4) tick();
    rst_n = 1'b0; #1;
    chk("mr_busy", bus.busy, 0);
    chk("mr_words", bus.words_sent, 0);
    chk("mr_key", bus.scan_key, 32'h0);
    tick(); rst_n = 1'b1; tick();
    wr(0, 32'h1234_5678);
    go();
    chk("mr_lock_cleared", bus.scan_key, 32'h1234_5678);
    tick();
    chk("mr_table_cleared", bus.scan_key, 32'h0);
    do_clear();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
